fs32bit_pipe: RTL and testbench

FS32BIT_PIPE -- requirements
Module: fs32bit_pipe

---
 rtl/fs32bit_pipe_if.sv | 27 ++
 rtl/fs32bit_pipe.sv | 97 +++++++++
 tb/tb_fs32bit_pipe.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fs32bit_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// master drives operands and out_ready; slave is the pipeline.
interface fs32bit_pipe_if #(
   parameter int N = 32
);
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] d;
   logic         bout;
   logic         ovf;
   logic         zero;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output a, b, bin, in_valid, out_ready,
      input  in_ready, d, bout, ovf, zero, out_valid
   );

   modport slave (
      input  a, b, bin, in_valid, out_ready,
      output in_ready, d, bout, ovf, zero, out_valid
   );
endinterface

// File: rtl/fs32bit_pipe.sv
// N-bit subtractor resolving SLICE bits per stage; the borrow crosses stages
// only through registers, with elastic per-stage valid/ready flow control.
module fs32bit_pipe #(
   parameter int N     = 32,
   parameter int SLICE = 8
) (
   input logic           clk,
   input logic           rst_n,
   fs32bit_pipe_if.slave bus
);
   localparam int P = N / SLICE;

   logic [P-1:0]        vld, rdy, v_in, br_in, br_nx, br_q;
   logic [P-1:0][N-1:0] a_q, b_q, d_q;
   logic [P-1:0][N-1:0] a_in, b_in, d_in, d_nx;
   logic                ovf_q, zero_q, ovf_nx, zero_nx;
   logic                unused_bits;

   // Stage k consumes what stage k-1 registered; stage 0 consumes the ports.
   always_comb begin
      v_in[0]  = bus.in_valid;
      a_in[0]  = bus.a;
      b_in[0]  = bus.b;
      d_in[0]  = '0;
      br_in[0] = bus.bin;
      for (int k = 1; k < P; k++) begin
         v_in[k]  = vld[k-1];
         a_in[k]  = a_q[k-1];
         b_in[k]  = b_q[k-1];
         d_in[k]  = d_q[k-1];
         br_in[k] = br_q[k-1];
      end
   end

   always_comb begin
      logic [SLICE:0] s;
      s = '0;
      for (int k = 0; k < P; k++) begin
         s = {1'b0, a_in[k][k*SLICE +: SLICE]} - {1'b0, b_in[k][k*SLICE +: SLICE]}
             - {{SLICE{1'b0}}, br_in[k]};
         d_nx[k] = d_in[k];
         d_nx[k][k*SLICE +: SLICE] = s[SLICE-1:0];
         br_nx[k] = s[SLICE];
      end
   end

   assign ovf_nx  = (a_in[P-1][N-1] != b_in[P-1][N-1]) && (d_nx[P-1][N-1] != a_in[P-1][N-1]);
   assign zero_nx = (d_nx[P-1] == '0);

   // A stage can load if it, or any stage downstream of it, has room.
   always_comb begin
      logic room;
      room = bus.out_ready;
      for (int k = P - 1; k >= 0; k--) begin
         room   = room || !vld[k];
         rdy[k] = room;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         d_q    <= '0;
         br_q   <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         for (int k = 0; k < P; k++) begin
            if (rdy[k]) begin
               vld[k] <= v_in[k];
               if (v_in[k]) begin
                  a_q[k]  <= a_in[k];
                  b_q[k]  <= b_in[k];
                  d_q[k]  <= d_nx[k];
                  br_q[k] <= br_nx[k];
               end
            end
         end
         if (rdy[P-1] && v_in[P-1]) begin
            ovf_q  <= ovf_nx;
            zero_q <= zero_nx;
         end
      end
   end

   // Consumed low slices and the last stage's operand copy have no reader.
   assign unused_bits = ^{a_in, b_in, a_q, b_q};

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = vld[P-1];
   assign bus.d         = d_q[P-1];
   assign bus.bout      = br_q[P-1];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_fs32bit_pipe.sv
// Directed and random checks of fs32bit_pipe; a monitor compares every
// delivered result against a queue of expected responses.
module tb_fs32bit_pipe;
   localparam int N = 32;

   typedef struct packed {
      logic [N-1:0] d;
      logic         bout;
      logic         ovf;
      logic         zero;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   rand_or = 1'b0;
   res_t sb[$];

   always #5 clk = ~clk;

   fs32bit_pipe_if #(.N(N)) bus ();
   fs32bit_pipe #(.N(N), .SLICE(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic res_t mk(input logic [N-1:0] d, input logic bout, input logic ovf,
                               input logic zero);
      res_t r;
      r.d = d; r.bout = bout; r.ovf = ovf; r.zero = zero;
      return r;
   endfunction

   // 33-bit reference for the random regression.
   function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
      logic [N:0] t;
      res_t r;
      t      = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
      r.d    = t[N-1:0];
      r.bout = t[N];
      r.ovf  = (a[N-1] != b[N-1]) && (t[N-1] != a[N-1]);
      r.zero = (t[N-1:0] == '0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input res_t e);
      int n;
      n = 0;
      @(negedge clk);
      bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
      forever begin
         #1;
         if (bus.in_ready) begin
            @(posedge clk);
            sb.push_back(e);
            #1 bus.in_valid = 1'b0;
            break;
         end
         @(negedge clk);
         n++;
         if (n > 200) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready stuck low for %0d cycles, required 1", n);
            bus.in_valid = 1'b0;
            break;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("drain_empty", N'(sb.size()), '0);
   endtask

   // Monitor: sampled after out_ready has settled for the coming edge.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output: got d=%0h with nothing pending, required none", bus.d);
            end else if (bus.out_ready) begin
               e = sb.pop_front();
               chk("d", bus.d, e.d);
               chk1("bout", bus.bout, e.bout);
               chk1("ovf", bus.ovf, e.ovf);
               chk1("zero", bus.zero, e.zero);
            end else begin
               chk("hold_d", bus.d, sb[0].d);
               chk1("hold_bout", bus.bout, sb[0].bout);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] ra, rb;
      logic         rbin;
      bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

      #12;
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_d", bus.d, '0);
      chk1("rst_in_ready", bus.in_ready, 1'b1);
      chk1("rst_flags", bus.bout | bus.ovf | bus.zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic operation and result latency.
      send(32'd5, 32'd3, 1'b0, mk(32'h2, 1'b0, 1'b0, 1'b0));
      repeat (3) @(negedge clk);
      #1 chk1("lat_early", bus.out_valid, 1'b0);
      @(negedge clk);
      #1 chk1("lat_on", bus.out_valid, 1'b1);

      send(32'h0, 32'h1, 1'b0, mk(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
      send(32'h7, 32'h7, 1'b0, mk(32'h0, 1'b0, 1'b0, 1'b1));
      send(32'h7, 32'h7, 1'b1, mk(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
      send(32'h80000000, 32'h1, 1'b0, mk(32'h7FFFFFFF, 1'b0, 1'b1, 1'b0));
      send(32'h01000000, 32'h1, 1'b0, mk(32'h00FFFFFF, 1'b0, 1'b0, 1'b0));
      send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, mk(32'h80000000, 1'b1, 1'b1, 1'b0));
      send(32'h0, 32'h0, 1'b1, mk(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
      send(32'h00010000, 32'h00000100, 1'b1, mk(32'h0000FEFF, 1'b0, 1'b0, 1'b0));
      drain();

      // Backpressure: four fill the pipe, the rest wait for out_ready.
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(32'(1000 * (i + 1)), 32'(i), 1'b0, mk(32'(1000 * (i + 1) - i), 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      #1 chk1("inrdy_full", bus.in_ready, 1'b0);
      fork
         begin
            @(negedge clk);
            bus.out_ready = 1'b1;
         end
         begin
            for (int i = 4; i < 8; i++)
               send(32'(1000 * (i + 1)), 32'(i), 1'b0, mk(32'(1000 * (i + 1) - i), 1'b0, 1'b0, 1'b0));
         end
      join
      drain();

      // Reset with three transactions in flight and one result presented.
      @(negedge clk);
      bus.out_ready = 1'b0;
      send(32'd50, 32'd1, 1'b0, mk(32'd49, 1'b0, 1'b0, 1'b0));
      send(32'd60, 32'd2, 1'b0, mk(32'd58, 1'b0, 1'b0, 1'b0));
      send(32'd70, 32'd3, 1'b0, mk(32'd67, 1'b0, 1'b0, 1'b0));
      repeat (2) @(negedge clk);
      #1 chk1("pre_rst_valid", bus.out_valid, 1'b1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
      chk("mid_rst_d", bus.d, '0);
      chk1("mid_rst_flags", bus.bout | bus.ovf | bus.zero, 1'b0);
      chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      bus.a = 32'd10; bus.b = 32'd4; bus.bin = 1'b0; bus.in_valid = 1'b1;
      #1 chk1("post_rst_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      sb.push_back(mk(32'd6, 1'b0, 1'b0, 1'b0));
      #1 bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk1("post_rst_lat_early", bus.out_valid, 1'b0);
      @(negedge clk);
      #1 chk1("post_rst_lat_on", bus.out_valid, 1'b1);
      chk("post_rst_d", bus.d, 32'd6);
      drain();

      // Random regression with random backpressure.
      rand_or = 1'b1;
      fork
         while (rand_or) begin
            @(negedge clk);
            if (rand_or) bus.out_ready = ($urandom_range(0, 3) != 0);
         end
      join_none
      for (int i = 0; i < 10000; i++) begin
         ra   = $urandom;
         rb   = ($urandom_range(0, 15) == 0) ? ra : $urandom;
         rbin = 1'($urandom_range(0, 1));
         send(ra, rb, rbin, model(ra, rb, rbin));
      end
      rand_or = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
